max_seq_ctrl: RTL and testbench

Sequential maximum finder. It accepts a frame of unsigned values one beat per cycle over a valid/ready stream and tracks the running maximum with a single shared greater-than comparator. At frame end it returns the maximum, the position of its first occurrence and the frame length over a valid/ready result port. It is the sequencing controller that lets the team's combinational max datapath handle frames of arbitrary length instead of a fixed two or three operands.

---
 rtl/max_seq_ctrl.sv | 110 +++++++++++
 tb/tb_max_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/max_seq_ctrl.sv
// Sequential frame maximum: tracks max, first index of max and length of a streamed frame.
// Latency: result valid the cycle after the last beat is accepted; one beat per cycle otherwise.
// Backpressure: in_ready drops while a result waits; it rises again the cycle after the result is taken.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_data is the value, in_last marks the frame end
//   out_valid/out_ready result handshake; out_max, out_idx, out_len, out_trunc are the result
module max_seq_ctrl #(
    parameter int WIDTH   = 8,
    parameter int MAX_LEN = 16,
    localparam int IW     = $clog2(MAX_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_max,
    output logic [IW-1:0]    out_idx,
    output logic [IW:0]      out_len,
    output logic             out_trunc
);

    localparam int CW = IW + 1;
    // Count value held just before the MAX_LEN-th beat is accepted.
    localparam logic [IW:0] LAST_CNT = CW'(MAX_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] max_q;
    logic [IW-1:0]    idx_q;
    logic [IW:0]      cnt_q;
    logic             trunc_q;

    logic accept;
    logic transfer;
    logic gt;
    logic at_limit;

    // Ready is masked by rst so a beat offered during reset is never consumed.
    assign in_ready  = !rst && (state_q != S_DONE);
    assign out_valid = (state_q == S_DONE);
    assign accept    = in_valid && in_ready;
    assign transfer  = out_valid && out_ready;

    // The single shared comparator; strict so ties keep the earlier index.
    assign gt        = (in_data > max_q);
    assign at_limit  = (cnt_q == LAST_CNT);

    assign out_max   = max_q;
    assign out_idx   = idx_q;
    assign out_len   = cnt_q;
    assign out_trunc = trunc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            max_q   <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        max_q   <= in_data;
                        idx_q   <= '0;
                        cnt_q   <= CW'(1);
                        trunc_q <= 1'b0;
                        state_q <= in_last ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        if (gt) begin
                            max_q <= in_data;
                            // cnt_q is the 0-based index of this beat and is below MAX_LEN here.
                            idx_q <= cnt_q[IW-1:0];
                        end
                        cnt_q <= cnt_q + CW'(1);
                        if (in_last) begin
                            state_q <= S_DONE;
                        end else if (at_limit) begin
                            // Forced end: later beats start the next frame.
                            state_q <= S_DONE;
                            trunc_q <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (transfer) begin
                        state_q <= S_IDLE;
                        trunc_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_max_seq_ctrl.sv
module tb_max_seq_ctrl;

    localparam int WIDTH   = 8;
    localparam int MAX_LEN = 16;
    localparam int IW      = $clog2(MAX_LEN);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_max;
    logic [IW-1:0]    out_idx;
    logic [IW:0]      out_len;
    logic             out_trunc;

    max_seq_ctrl #(.WIDTH(WIDTH), .MAX_LEN(MAX_LEN)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_max   (out_max),
        .out_idx   (out_idx),
        .out_len   (out_len),
        .out_trunc (out_trunc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] mx;
        int               idx;
        int               len;
        logic             tr;
    } res_t;

    typedef struct {
        logic             v;
        logic [WIDTH-1:0] d;
        logic             l;
        logic             o;
        logic             e_ir;
        logic             e_ov;
        logic             chk;
        logic [WIDTH-1:0] e_max;
        int               e_idx;
        int               e_len;
        logic             e_tr;
    } vec_t;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: beats of the frame in progress and results not yet taken.
    logic [WIDTH-1:0] cur_q[$];
    res_t             exp_q[$];
    res_t             dut_log[$];

    // Outputs sampled in the most recent step.
    logic             s_ir, s_ov, s_tr;
    logic [WIDTH-1:0] s_max;
    int               s_idx, s_len;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Frame result straight from the list of beats: largest value, first position, count.
    function automatic res_t frame_result(input logic last_flag);
        res_t r;
        r.mx  = cur_q[0];
        r.idx = 0;
        for (int i = 1; i < cur_q.size(); i++) begin
            if (cur_q[i] > r.mx) begin
                r.mx  = cur_q[i];
                r.idx = i;
            end
        end
        r.len = cur_q.size();
        r.tr  = !last_flag;
        return r;
    endfunction

    // One clock: drive after the edge, sample and check on the falling edge, then advance the model.
    task automatic step(input logic r, input logic v, input logic [WIDTH-1:0] d,
                        input logic l, input logic o);
        logic exp_ir;
        @(posedge clk);
        #1;
        rst = r; in_valid = v; in_data = d; in_last = l; out_ready = o;
        @(negedge clk);
        s_ir = in_ready; s_ov = out_valid; s_max = out_max;
        s_idx = int'(out_idx); s_len = int'(out_len); s_tr = out_trunc;

        exp_ir = !r && (exp_q.size() == 0);
        chk("model_in_ready", in_ready, exp_ir);
        if (!r) begin
            chk("model_out_valid", out_valid, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                chk("model_max", out_max, exp_q[0].mx);
                chk("model_idx", out_idx, exp_q[0].idx);
                chk("model_len", out_len, exp_q[0].len);
                chk("model_trunc", out_trunc, exp_q[0].tr);
            end
            if (out_valid && o) dut_log.push_back('{out_max, int'(out_idx), int'(out_len), out_trunc});
        end

        if (r) begin
            cur_q.delete();
            exp_q.delete();
        end else begin
            if (o && exp_q.size() != 0) void'(exp_q.pop_front());
            if (v && exp_ir) begin
                cur_q.push_back(d);
                if (l || cur_q.size() == MAX_LEN) begin
                    exp_q.push_back(frame_result(l));
                    cur_q.delete();
                end
            end
        end
    endtask

    function automatic vec_t mk(input logic v, input int d, input logic l, input logic o,
                                input logic e_ir, input logic e_ov, input logic c,
                                input int e_max, input int e_idx, input int e_len, input logic e_tr);
        vec_t t;
        t.v = v; t.d = WIDTH'(d); t.l = l; t.o = o;
        t.e_ir = e_ir; t.e_ov = e_ov; t.chk = c;
        t.e_max = WIDTH'(e_max); t.e_idx = e_idx; t.e_len = e_len; t.e_tr = e_tr;
        return t;
    endfunction

    task automatic check_log(input string name, input int k, input int mx, input int idx,
                             input int len, input logic tr);
        if (dut_log.size() <= k) begin
            chk({name, "_missing"}, dut_log.size(), k + 1);
        end else begin
            chk({name, "_max"}, dut_log[k].mx, mx);
            chk({name, "_idx"}, dut_log[k].idx, idx);
            chk({name, "_len"}, dut_log[k].len, len);
            chk({name, "_trunc"}, dut_log[k].tr, tr);
        end
    endtask

    vec_t tbl[21];

    initial begin
        int tries;
        int n_xfer;
        logic [WIDTH-1:0] rd;

        // Frame 3,9,2,9,5; single 0xFF; frame 0,0,0,0; gapped 4,_,8,_,_,6.
        tbl[0]  = mk(1, 3,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[1]  = mk(1, 9,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[2]  = mk(1, 2,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[3]  = mk(1, 9,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[4]  = mk(1, 5,    1, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[5]  = mk(0, 0,    0, 1, 0, 1, 1, 9,    1, 5, 0);
        tbl[6]  = mk(1, 255,  1, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[7]  = mk(1, 0,    0, 1, 0, 1, 1, 255,  0, 1, 0);
        tbl[8]  = mk(1, 0,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[9]  = mk(1, 0,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[10] = mk(1, 0,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[11] = mk(1, 0,    1, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[12] = mk(0, 0,    0, 1, 0, 1, 1, 0,    0, 4, 0);
        tbl[13] = mk(1, 4,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[14] = mk(0, 77,   1, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[15] = mk(1, 8,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[16] = mk(0, 99,   1, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[17] = mk(0, 0,    0, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[18] = mk(1, 6,    1, 1, 1, 0, 0, 0,    0, 0, 0);
        tbl[19] = mk(0, 0,    0, 1, 0, 1, 1, 8,    1, 3, 0);
        tbl[20] = mk(0, 0,    0, 1, 1, 0, 0, 0,    0, 0, 0);

        // Reset, then reset values.
        step(1, 1, 8'd42, 1, 1);
        step(1, 0, 8'd0, 0, 0);
        chk("rst_in_ready", s_ir, 0);
        step(0, 0, 8'd0, 0, 0);
        chk("rst_in_ready_after", s_ir, 1);
        chk("rst_out_valid", s_ov, 0);
        chk("rst_out_max", s_max, 0);
        chk("rst_out_idx", s_idx, 0);
        chk("rst_out_len", s_len, 0);
        chk("rst_out_trunc", s_tr, 0);

        for (int i = 0; i < 21; i++) begin
            step(0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
            chk($sformatf("tbl%0d_in_ready", i), s_ir, tbl[i].e_ir);
            chk($sformatf("tbl%0d_out_valid", i), s_ov, tbl[i].e_ov);
            if (tbl[i].chk) begin
                chk($sformatf("tbl%0d_max", i), s_max, tbl[i].e_max);
                chk($sformatf("tbl%0d_idx", i), s_idx, tbl[i].e_idx);
                chk($sformatf("tbl%0d_len", i), s_len, tbl[i].e_len);
                chk($sformatf("tbl%0d_trunc", i), s_tr, tbl[i].e_tr);
            end
        end

        // Backpressure: result held, nothing accepted while the consumer stalls.
        step(0, 1, 8'd7, 0, 0);
        step(0, 1, 8'd1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'd99, 0, 0);
            chk("bp_in_ready", s_ir, 0);
            chk("bp_out_valid", s_ov, 1);
            chk("bp_max", s_max, 7);
            chk("bp_idx", s_idx, 0);
            chk("bp_len", s_len, 2);
        end
        step(0, 1, 8'd99, 0, 1);
        chk("bp_xfer_in_ready", s_ir, 0);
        chk("bp_xfer_out_valid", s_ov, 1);
        step(0, 0, 8'd0, 0, 1);
        chk("bp_ready_returns", s_ir, 1);
        chk("bp_valid_drops", s_ov, 0);

        // Truncation: 20 ascending beats, in_last only on the 20th.
        dut_log.delete();
        for (int b = 1; b <= 20; b++) begin
            tries = 0;
            do begin
                step(0, 1, WIDTH'(b), b == 20, 1);
                tries++;
            end while (!s_ir && tries < 5);
            if (!s_ir) chk("trunc_beat_accept_timeout", 0, 1);
        end
        step(0, 0, 8'd0, 0, 1);
        step(0, 0, 8'd0, 0, 1);
        chk("trunc_result_count", dut_log.size(), 2);
        check_log("trunc_first", 0, 16, 15, 16, 1);
        check_log("trunc_second", 1, 20, 3, 4, 0);

        // Reset one cycle mid-frame: the partial frame is dropped.
        dut_log.delete();
        step(0, 1, 8'd50, 0, 1);
        step(0, 1, 8'd60, 0, 1);
        step(0, 1, 8'd70, 0, 1);
        step(1, 1, 8'd5, 1, 1);
        chk("abort_in_ready", s_ir, 0);
        step(0, 1, 8'd10, 0, 1);
        step(0, 1, 8'd20, 1, 1);
        step(0, 0, 8'd0, 0, 1);
        step(0, 0, 8'd0, 0, 1);
        chk("abort_result_count", dut_log.size(), 1);
        check_log("abort", 0, 20, 1, 2, 0);

        // Random traffic against the model, with occasional resets and narrow data for ties.
        n_xfer = 0;
        dut_log.delete();
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 1) == 0) rd = WIDTH'($urandom_range(0, 3));
            else rd = WIDTH'($urandom_range(0, 255));
            step($urandom_range(0, 299) == 0, $urandom_range(0, 9) < 7, rd,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 9) < 6);
        end
        n_xfer = dut_log.size();
        if (n_xfer < 50) chk("random_result_activity", n_xfer, 50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
